prog_clk_div: RTL and testbench
===============================

// Module: prog_clk_div
// PURPOSE
//   Parametrised programmable clock divider. Generates a near-50% duty divided clock
//   (clk_out) and a one-cycle strobe (tick) from clk_in for any integer ratio N.
//   Ratio changes take effect only at a period boundary, so clk_out never emits a runt pulse.
//   Feeds display-scan, debounce-sample and LED-blink logic from the board clock.
// PARAMETERS
//   DIV_W    12   width of divisor request/counter; N range 2 .. 2**DIV_W-1
//   DEF_DIV  4096 divisor active after reset; clamped to [2, 2**DIV_W-1] at elaboration
// PORTS
//   clk_in   in   1      board clock, all logic on posedge
//   rst      in   1      synchronous reset, active-high
//   en       in   1      count enable; 0 freezes divider state
//   div_req  in   DIV_W  requested divisor N
//   div_load in   1      strobe: capture div_req as pending divisor
//   clk_out  out  1      divided clock, registered
//   tick     out  1      1-cycle pulse coinciding with each clk_out rising edge, registered
//   div_cur  out  DIV_W  divisor currently in effect
//   pend     out  1      a loaded divisor awaits the next period boundary
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge): cnt=DEF_DIV-1, div_cur=DEF_DIV, clk_out=0, tick=0,
//     pend=0, pending reg=0. rst has priority over all other inputs.
//   Clamp: any div_req < 2 is captured as 2.
//   Internal: cnt (DIV_W bits) counts 0..div_cur-1; H = ceil(div_cur/2) high cycles.
//   Each posedge with en=1:
//     wrap      = (cnt == div_cur-1)
//     cnt_next  = wrap ? 0 : cnt+1
//     at wrap:  div_cur <= captured value if pend (or div_load this cycle), else unchanged;
//               pend <= 0
//     clk_out  <= (cnt_next < H_eff); H_eff uses the divisor in effect after this edge
//     tick     <= wrap
//   Hence clk_out period = N clk_in cycles; high H, low N-H (even N: exact 50%;
//   odd N: high one cycle longer). tick and clk_out rise on the same edge.
//   First enabled cycle after reset is a wrap: tick=1, clk_out=1.
//   div_load handling (independent of en):
//     not at wrap: pending <= clamp(div_req), pend <= 1 on next edge
//     repeated loads before boundary: last value wins
//     load in same cycle as an enabled wrap: applied at that wrap directly, pend stays 0
//     load of value equal to div_cur: still sets pend; boundary applies it (no visible change)
//   en=0: cnt, clk_out, div_cur held; tick forced 0 next edge; pending capture still works.
//   Reset mid-period: all state returns to reset values at that edge, pending discarded.
//   No combinational path from any input to any output.
// TESTING
//   1 rst, DEF_DIV=4, en=1 -> clk_out 1,1,0,0 repeating; tick on every 4th cycle, first
//     on first enabled cycle.
//   2 load N=5 -> clk_out 1,1,1,0,0 repeating; tick period 5.
//   3 N=8 running, load N=3 at cnt=2 -> pend=1, current period completes 8 cycles,
//     then 1,1,0; pend=0, div_cur=3 at wrap.
//   4 load N=6 exactly on wrap cycle -> next period already 6 cycles, pend never 1;
//     two loads (7 then 9) before boundary -> 9 applied.
//   5 div_req=0 and 1 with load -> div_cur=2, clk_out toggles every cycle.
//   6 en=0 for 10 cycles mid high phase -> clk_out held 1, tick 0, cnt frozen;
//     rst asserted mid-period -> reset values next edge, pend cleared.

Source files
------------

// File: rtl/prog_clk_div_if.sv
// prog_clk_div_if
//   Groups the control and status signals of the programmable clock divider.
//   master: the controlling logic (drives enable and divisor loads, sees status).
//   slave : the divider itself.
//   Signals:
//     en       count enable; 0 freezes the divider
//     div_req  requested divisor N (DIV_W bits)
//     div_load strobe: capture div_req as the pending divisor
//     clk_out  divided clock (registered)
//     tick     one-cycle strobe on each clk_out rising edge (registered)
//     div_cur  divisor currently in effect
//     pend     a loaded divisor is waiting for the next period boundary
interface prog_clk_div_if #(
  parameter int DIV_W = 12
);
  logic             en;
  logic [DIV_W-1:0] div_req;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [DIV_W-1:0] div_cur;
  logic             pend;

  modport master (
    output en, div_req, div_load,
    input  clk_out, tick, div_cur, pend
  );

  modport slave (
    input  en, div_req, div_load,
    output clk_out, tick, div_cur, pend
  );
endinterface

// File: rtl/prog_clk_div.sv
// prog_clk_div
//   Programmable integer clock divider. Produces a near-50% duty divided clock
//   and a one-cycle tick aligned with each of its rising edges. A new divisor
//   only takes effect at a period boundary, so clk_out never shows a runt pulse.
//   Ports:
//     clk_in  board clock, all logic on its rising edge
//     rst     synchronous reset, active-high, highest priority
//     bus     prog_clk_div_if slave modport (en, div_req, div_load in;
//             clk_out, tick, div_cur, pend out)
//   Parameters:
//     DIV_W    counter / divisor width, N range 2 .. 2**DIV_W-1
//     DEF_DIV  divisor after reset, clamped into the legal range
module prog_clk_div #(
  parameter int DIV_W   = 12,
  parameter int DEF_DIV = 4096
) (
  input  logic            clk_in,
  input  logic            rst,
  prog_clk_div_if.slave   bus
);

  localparam int MAX_DIV = (1 << DIV_W) - 1;
  localparam int DEF_CLAMPED = (DEF_DIV < 2) ? 2 :
                               (DEF_DIV > MAX_DIV) ? MAX_DIV : DEF_DIV;
  localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_CLAMPED);

  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic [DIV_W-1:0] div_cur_q,  div_cur_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q,     pend_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;

  logic [DIV_W-1:0] load_val;
  logic             wrap;
  logic [DIV_W:0]   h_eff;

  always_comb begin
    // Divisors below 2 cannot produce a clock; force them to 2.
    load_val = (bus.div_req < DIV_W'(2)) ? DIV_W'(2) : bus.div_req;
    wrap     = (cnt_q == (div_cur_q - DIV_W'(1)));

    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    if (bus.en && wrap) begin
      // Period boundary: a load in this very cycle beats an older pending one.
      cnt_d  = '0;
      tick_d = 1'b1;
      pend_d = 1'b0;
      if (bus.div_load) begin
        div_cur_d = load_val;
      end else if (pend_q) begin
        div_cur_d = pend_val_q;
      end
    end else begin
      if (bus.en) begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      // Capture works regardless of enable; the last load before a boundary wins.
      if (bus.div_load) begin
        pend_val_d = load_val;
        pend_d     = 1'b1;
      end
    end

    // High phase length uses the divisor in effect after this edge so the
    // first cycle of a new period already follows the new ratio.
    h_eff = ({1'b0, div_cur_d} + (DIV_W+1)'(1)) >> 1;
    if (bus.en) begin
      clk_out_d = ({1'b0, cnt_d} < h_eff);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q      <= DEF_V - DIV_W'(1);
      div_cur_q  <= DEF_V;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.div_cur = div_cur_q;
  assign bus.pend    = pend_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div
//   Directed scenarios followed by randomized traffic, checked against a
//   waveform-level reference: each period is expanded into a queue of
//   (clk_out, tick) samples that is consumed one enabled cycle at a time.
module tb_prog_clk_div;

  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 4;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  always #5 clk_in = ~clk_in;

  prog_clk_div_if #(.DIV_W(DIV_W)) bus ();

  prog_clk_div #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  bit q_clk[$];
  bit q_tick[$];
  bit m_clk, m_tick, m_pend;
  int m_div, m_pval;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_clk.delete();
    q_tick.delete();
    m_clk  = 0;
    m_tick = 0;
    m_pend = 0;
    m_pval = 0;
    m_div  = DEF_DIV;
  endtask

  // One clock cycle: drive inputs, advance reference, compare all outputs.
  task automatic cyc(input bit e, input bit ld, input logic [DIV_W-1:0] req, input bit r);
    int lv;
    int nd;
    bus.en       = e;
    bus.div_load = ld;
    bus.div_req  = req;
    rst          = r;
    @(posedge clk_in);
    lv = (int'(req) < 2) ? 2 : int'(req);
    if (r) begin
      model_reset();
    end else if (e) begin
      if (q_clk.size() == 0) begin
        nd = ld ? lv : (m_pend ? m_pval : m_div);
        m_div  = nd;
        m_pend = 0;
        for (int i = 0; i < nd; i++) begin
          q_clk.push_back(i < (nd + 1) / 2);
          q_tick.push_back(i == 0);
        end
      end else if (ld) begin
        m_pval = lv;
        m_pend = 1;
      end
      m_clk  = q_clk.pop_front();
      m_tick = q_tick.pop_front();
    end else begin
      m_tick = 0;
      if (ld) begin
        m_pval = lv;
        m_pend = 1;
      end
    end
    #1;
    chk("clk_out", 32'(bus.clk_out), 32'(m_clk));
    chk("tick",    32'(bus.tick),    32'(m_tick));
    chk("div_cur", 32'(bus.div_cur), 32'(m_div));
    chk("pend",    32'(bus.pend),    32'(m_pend));
    $display("t=%0t rst=%0b en=%0b ld=%0b req=%0d | clk_out=%0b tick=%0b div_cur=%0d pend=%0b",
             $time, r, e, ld, req, bus.clk_out, bus.tick, bus.div_cur, bus.pend);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, '0, 0);
  endtask

  initial begin
    bit found;
    bit exp_pat[4];
    exp_pat[0] = 1; exp_pat[1] = 1; exp_pat[2] = 0; exp_pat[3] = 0;

    bus.en = 0; bus.div_load = 0; bus.div_req = '0;
    model_reset();

    // Reset state
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("rst_tick",    32'(bus.tick),    32'd0);
    chk("rst_div_cur", 32'(bus.div_cur), 32'd4);
    chk("rst_pend",    32'(bus.pend),    32'd0);

    // Default divisor 4: 1,1,0,0 with tick on the first enabled cycle
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, '0, 0);
      chk("n4_pattern", 32'(bus.clk_out), 32'(exp_pat[i % 4]));
      chk("n4_tick",    32'(bus.tick),    32'(i % 4 == 0));
    end

    // Load N=5
    cyc(1, 1, 8'd5, 0);
    run(20);

    // N=8 running, then load 3 when cnt=2
    cyc(1, 1, 8'd8, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_div == 8 && q_clk.size() == 5) found = 1;
      else cyc(1, 0, '0, 0);
    end
    chk("reach_cnt2", 32'(found), 32'd1);
    cyc(1, 1, 8'd3, 0);
    chk("n3_pend", 32'(bus.pend), 32'd1);
    run(12);
    chk("n3_applied", 32'(bus.div_cur), 32'd3);

    // Load 6 exactly on the wrap cycle
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (q_clk.size() == 0) found = 1;
      else cyc(1, 0, '0, 0);
    end
    chk("reach_wrap", 32'(found), 32'd1);
    cyc(1, 1, 8'd6, 0);
    chk("n6_direct", 32'(bus.div_cur), 32'd6);
    chk("n6_nopend", 32'(bus.pend),    32'd0);
    run(2);
    cyc(1, 1, 8'd7, 0);
    cyc(1, 1, 8'd9, 0);
    run(12);
    chk("last_wins", 32'(bus.div_cur), 32'd9);

    // Clamp of 0 and 1
    cyc(1, 1, 8'd0, 0);
    run(12);
    chk("clamp0", 32'(bus.div_cur), 32'd2);
    cyc(1, 1, 8'd1, 0);
    run(6);
    chk("clamp1", 32'(bus.div_cur), 32'd2);

    // N=10, freeze in the high phase, then reset mid-period with a pending load
    cyc(1, 1, 8'd10, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_div == 10 && q_clk.size() == 7) found = 1;
      else cyc(1, 0, '0, 0);
    end
    chk("reach_high", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, (i == 4), 8'd6, 0);
      chk("frz_clk", 32'(bus.clk_out), 32'd1);
      chk("frz_tick", 32'(bus.tick),   32'd0);
    end
    chk("frz_pend", 32'(bus.pend), 32'd1);
    run(3);
    cyc(1, 0, '0, 1);
    chk("mid_rst_div",  32'(bus.div_cur), 32'd4);
    chk("mid_rst_pend", 32'(bus.pend),    32'd0);
    chk("mid_rst_clk",  32'(bus.clk_out), 32'd0);
    run(8);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [DIV_W-1:0] req;
      if ($urandom_range(0, 19) == 0) req = DIV_W'($urandom_range(0, 40));
      else req = DIV_W'($urandom_range(0, 12));
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, req,
          $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
